// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed byte stream, writes 16-bit
// words into instruction memory and holds the core in reset until verified.
module imem_boot_loader #(
    parameter int          MAX_WORDS = 256,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [15:0] imem_addr,
    output logic [15:0] imem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [16:0] MAX_L = 17'(MAX_WORDS);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [7:0]  data_hi;
    logic [7:0]  xor_acc;
    logic        xfer;
    logic        restart;
    logic [16:0] len_in;
    logic        last_word;

    assign xfer      = byte_valid & byte_ready;
    assign restart   = start & ((state == DONE) | (state == ERROR));
    assign len_in    = {1'b0, len_hi, byte_in};
    assign last_word = (word_count + 16'd1) == len;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= LEN_HI;
        else     state <= state_nxt;
    end

    // Next-state decode; every advance needs a byte transfer
    always_comb begin
        state_nxt = state;
        case (state)
            LEN_HI:  if (xfer) state_nxt = LEN_LO;
            LEN_LO: begin
                if (xfer) begin
                    if (len_in == 17'd0)   state_nxt = CHECK;
                    else if (len_in > MAX_L) state_nxt = ERROR;
                    else                   state_nxt = DATA_HI;
                end
            end
            DATA_HI: if (xfer) state_nxt = DATA_LO;
            DATA_LO: begin
                if (xfer) state_nxt = last_word ? CHECK : DATA_HI;
            end
            CHECK: begin
                if (xfer) state_nxt = (byte_in == xor_acc) ? DONE : ERROR;
            end
            DONE:    if (restart) state_nxt = LEN_HI;
            ERROR:   if (restart) state_nxt = LEN_HI;
            default: state_nxt = LEN_HI;
        endcase
    end

    // Status outputs follow the state directly
    always_comb begin
        byte_ready = 1'b0;
        cpu_rst    = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK: byte_ready = 1'b1;
            DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            ERROR:   error = 1'b1;
            default: ;
        endcase
    end

    // Datapath: length capture, word assembly, checksum and write strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            len_hi     <= 8'd0;
            len        <= 16'd0;
            data_hi    <= 8'd0;
            xor_acc    <= 8'd0;
            word_count <= 16'd0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= 16'd0;
        end else begin
            imem_we <= 1'b0;
            if (restart) begin
                xor_acc    <= 8'd0;
                word_count <= 16'd0;
                imem_addr  <= BASE_ADDR;
            end else if (xfer) begin
                case (state)
                    LEN_HI: len_hi <= byte_in;
                    LEN_LO: len    <= len_in[15:0];
                    DATA_HI: begin
                        data_hi <= byte_in;
                        xor_acc <= xor_acc ^ byte_in;
                    end
                    DATA_LO: begin
                        xor_acc    <= xor_acc ^ byte_in;
                        imem_we    <= 1'b1;
                        imem_wdata <= {data_hi, byte_in};
                        imem_addr  <= BASE_ADDR + {word_count[14:0], 1'b0};
                        word_count <= word_count + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed scenarios for imem_boot_loader with
// hand-computed expected writes and status values.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] log_addr[$];
    logic [15:0] log_data[$];
    logic [15:0] log_wc[$];

    imem_boot_loader dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst),
        .done(done),
        .error(error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    // Record every write strobe away from the active edge
    always @(negedge clk) begin
        if (imem_we) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
            log_wc.push_back(word_count);
        end
    end

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_wc.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        clear_log();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        idle(1);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 20) begin
            idle(1);
            n++;
        end
        checks++;
        if (!byte_ready) begin
            $display("FAIL send_timeout: byte %h not accepted, ready=%b", b, byte_ready);
            errors++;
        end else begin
            idle(1);
        end
        byte_valid = 1'b0;
    endtask

    task automatic check_writes(input string name, input int n,
                                input logic [15:0] ea [4],
                                input logic [15:0] ed [4]);
        checks++;
        if (log_addr.size() != n) begin
            $display("FAIL %s_count: got %0d writes, expected %0d", name, log_addr.size(), n);
            errors++;
        end
        for (int i = 0; i < n && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== ea[i] || log_data[i] !== ed[i] ||
                log_wc[i] !== 16'(i + 1)) begin
                $display("FAIL %s_w%0d: got addr=%h data=%h wc=%h, expected addr=%h data=%h wc=%h",
                         name, i, log_addr[i], log_data[i], log_wc[i], ea[i], ed[i], 16'(i + 1));
                errors++;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cpu_rst, done, error, imem_we, byte_ready} !== 5'b10001) begin
            $display("FAIL reset_flags: got cpu_rst,done,error,we,ready=%b expected 10001",
                     {cpu_rst, done, error, imem_we, byte_ready});
            errors++;
        end
        checks++;
        if (imem_addr !== 16'h0000 || imem_wdata !== 16'h0000 || word_count !== 16'h0000) begin
            $display("FAIL reset_regs: got addr=%h wdata=%h wc=%h expected 0000 0000 0000",
                     imem_addr, imem_wdata, word_count);
            errors++;
        end
    endtask

    task automatic test_good_image();
        logic [15:0] ea [4] = '{16'h0000, 16'h0002, 16'h0, 16'h0};
        logic [15:0] ed [4] = '{16'h1234, 16'hABCD, 16'h0, 16'h0};
        logic [7:0]  s  [7] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        do_reset();
        for (int i = 0; i < 7; i++) send(s[i]);
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || error !== 1'b0) begin
            $display("FAIL good_status: got done=%b cpu_rst=%b error=%b expected 1 0 0",
                     done, cpu_rst, error);
            errors++;
        end
        check_writes("good", 2, ea, ed);
        idle(3);
        checks++;
        if (done !== 1'b1 || word_count !== 16'd2 || byte_ready !== 1'b0) begin
            $display("FAIL good_hold: got done=%b wc=%h ready=%b expected 1 0002 0",
                     done, word_count, byte_ready);
            errors++;
        end
    endtask

    task automatic test_bad_checksum();
        logic [15:0] ea [4] = '{16'h0000, 16'h0002, 16'h0, 16'h0};
        logic [15:0] ed [4] = '{16'h1234, 16'hABCD, 16'h0, 16'h0};
        logic [7:0]  s  [7] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        clear_log();
        pulse_start();
        checks++;
        if (done !== 1'b0 || cpu_rst !== 1'b1 || word_count !== 16'd0 || imem_addr !== 16'h0000) begin
            $display("FAIL restart: got done=%b cpu_rst=%b wc=%h addr=%h expected 0 1 0000 0000",
                     done, cpu_rst, word_count, imem_addr);
            errors++;
        end
        for (int i = 0; i < 7; i++) send(s[i]);
        idle(3);
        checks++;
        if (error !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b0) begin
            $display("FAIL badsum_status: got error=%b cpu_rst=%b done=%b ready=%b expected 1 1 0 0",
                     error, cpu_rst, done, byte_ready);
            errors++;
        end
        check_writes("badsum", 2, ea, ed);
    endtask

    task automatic test_len_too_big();
        logic [15:0] ea [4] = '{default: 16'h0};
        logic [15:0] ed [4] = '{default: 16'h0};
        clear_log();
        pulse_start();
        send(8'h01);
        checks++;
        if (error !== 1'b0) begin
            $display("FAIL biglen_early: got error=%b expected 0", error);
            errors++;
        end
        send(8'h01);
        checks++;
        if (error !== 1'b1 || cpu_rst !== 1'b1 || byte_ready !== 1'b0) begin
            $display("FAIL biglen_status: got error=%b cpu_rst=%b ready=%b expected 1 1 0",
                     error, cpu_rst, byte_ready);
            errors++;
        end
        byte_in    = 8'h55;
        byte_valid = 1'b1;
        idle(4);
        byte_valid = 1'b0;
        check_writes("biglen", 0, ea, ed);
    endtask

    task automatic test_zero_len();
        logic [15:0] ea [4] = '{default: 16'h0};
        logic [15:0] ed [4] = '{default: 16'h0};
        do_reset();
        send(8'h00);
        send(8'h00);
        send(8'h00);
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || word_count !== 16'd0) begin
            $display("FAIL zerolen_status: got done=%b cpu_rst=%b wc=%h expected 1 0 0000",
                     done, cpu_rst, word_count);
            errors++;
        end
        check_writes("zerolen", 0, ea, ed);
    endtask

    task automatic test_gaps();
        logic [15:0] ea [4] = '{16'h0000, 16'h0002, 16'h0004, 16'h0};
        logic [15:0] ed [4] = '{16'h1122, 16'h3344, 16'h5566, 16'h0};
        logic [7:0]  s  [9] = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33,
                                8'h44, 8'h55, 8'h66, 8'h77};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            send(s[i]);
            byte_in = 8'hFF;
            if (i == 4) start = 1'b1;
            idle(1);
            start = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || error !== 1'b0 || word_count !== 16'd3) begin
            $display("FAIL gaps_status: got done=%b cpu_rst=%b error=%b wc=%h expected 1 0 0 0003",
                     done, cpu_rst, error, word_count);
            errors++;
        end
        check_writes("gaps", 3, ea, ed);
    endtask

    task automatic test_rst_midstream();
        logic [15:0] ea [4] = '{16'h0000, 16'h0, 16'h0, 16'h0};
        logic [15:0] ed [4] = '{16'hDEAD, 16'h0, 16'h0, 16'h0};
        logic [7:0]  s  [5] = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'h73};
        do_reset();
        send(8'h00);
        send(8'h03);
        send(8'hAA);
        send(8'hBB);
        send(8'hCC);
        checks++;
        if (log_addr.size() != 1 || word_count !== 16'd1) begin
            $display("FAIL mid_pre: got %0d writes wc=%h expected 1 0001", log_addr.size(), word_count);
            errors++;
        end
        rst        = 1'b1;
        byte_in    = 8'hDD;
        byte_valid = 1'b1;
        idle(2);
        byte_valid = 1'b0;
        rst        = 1'b0;
        clear_log();
        idle(2);
        checks++;
        if (log_addr.size() != 0 || word_count !== 16'd0 || imem_addr !== 16'h0000 ||
            byte_ready !== 1'b1 || cpu_rst !== 1'b1) begin
            $display("FAIL mid_abandon: got %0d writes wc=%h addr=%h ready=%b cpu_rst=%b expected 0 0000 0000 1 1",
                     log_addr.size(), word_count, imem_addr, byte_ready, cpu_rst);
            errors++;
        end
        pulse_start();
        for (int i = 0; i < 5; i++) send(s[i]);
        checks++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || word_count !== 16'd1) begin
            $display("FAIL mid_reload: got done=%b cpu_rst=%b wc=%h expected 1 0 0001",
                     done, cpu_rst, word_count);
            errors++;
        end
        check_writes("mid", 1, ea, ed);
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        test_reset();
        test_good_image();
        test_bad_checksum();
        test_len_too_big();
        test_zero_len();
        test_gaps();
        test_rst_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
